// File: rtl/solar_motor_drive_if.sv
// solar_motor_drive_if: tracker motor requests in, stepper step/dir and status out.
interface solar_motor_drive_if #(parameter int POS_W = 8);
    logic             mn, me, ms, mw;
    logic             step_ns, step_ew, dir_ns, dir_ew;
    logic [POS_W-1:0] pos_ns, pos_ew;
    logic             limit, fault, busy;
    modport master (output mn, me, ms, mw,
                    input step_ns, step_ew, dir_ns, dir_ew, pos_ns, pos_ew, limit, fault, busy);
    modport slave  (input mn, me, ms, mw,
                    output step_ns, step_ew, dir_ns, dir_ew, pos_ns, pos_ew, limit, fault, busy);
endinterface

// File: rtl/solar_motor_drive.sv
// solar_motor_drive: one-hot tracker requests to rate-limited step/dir trains with dead-time.
// Define SOLAR_DRV_SOFTLIMIT_EN to enable position counters and soft-limit blocking.
module solar_motor_drive #(
    parameter int STEP_DIV    = 16,
    parameter int DEAD_CYCLES = 8,
    parameter int POS_W       = 8,
    parameter int POS_MAX     = 255,
    parameter int POS_INIT    = 128
) (
    input logic                clk,
    input logic                rst_n,
    solar_motor_drive_if.slave bus
);
    localparam int CW = $clog2(STEP_DIV > DEAD_CYCLES ? STEP_DIV : DEAD_CYCLES);
    localparam logic [CW-1:0] SD1 = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] DC1 = CW'(DEAD_CYCLES - 1);

    if (STEP_DIV < 2 || DEAD_CYCLES < 1 || POS_MAX >= 2**POS_W || POS_INIT > POS_MAX) begin : g_bad
        $error("solar_motor_drive: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    req_q, cur_q, cur_d;
    logic          dir_ns_q, dir_ns_d, dir_ew_q, dir_ew_d;
    logic          valid, blocked, step;

    // Request bit order is {mn, me, ms, mw}: [3]/[1] drive the ns axis, [3]/[2] increment.
    assign valid = $onehot(req_q);
    assign step  = state_q == RUN && cnt_q == '0 && req_q == cur_q && !blocked;

`ifdef SOLAR_DRV_SOFTLIMIT_EN
    localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
    logic [POS_W-1:0] pos_ns_q, pos_ew_q;
    assign blocked = (req_q[3] && pos_ns_q == PMAX) || (req_q[1] && pos_ns_q == '0) ||
                     (req_q[2] && pos_ew_q == PMAX) || (req_q[0] && pos_ew_q == '0);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pos_ns_q <= POS_W'(POS_INIT);
            pos_ew_q <= POS_W'(POS_INIT);
        end else if (step) begin
            if (cur_q[3]) pos_ns_q <= pos_ns_q + 1'b1;
            if (cur_q[1]) pos_ns_q <= pos_ns_q - 1'b1;
            if (cur_q[2]) pos_ew_q <= pos_ew_q + 1'b1;
            if (cur_q[0]) pos_ew_q <= pos_ew_q - 1'b1;
        end
    assign bus.pos_ns = pos_ns_q;
    assign bus.pos_ew = pos_ew_q;
`else
    assign blocked    = 1'b0;
    assign bus.pos_ns = '0;
    assign bus.pos_ew = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        dir_ns_d = dir_ns_q;
        dir_ew_d = dir_ew_q;
        case (state_q)
            IDLE: if (valid && !blocked) begin
                state_d = RUN;
                cnt_d   = SD1;
                cur_d   = req_q;
                if (req_q[3] || req_q[1]) dir_ns_d = req_q[3];
                else                      dir_ew_d = req_q[2];
            end
            RUN: if (req_q != cur_q || (cnt_q == '0 && blocked)) begin
                state_d = DEAD;
                cnt_d   = DC1;
            end else begin
                cnt_d = cnt_q == '0 ? SD1 : cnt_q - 1'b1;
            end
            DEAD: begin
                state_d = cnt_q == '0 ? IDLE : DEAD;
                cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            cur_q    <= '0;
            dir_ns_q <= 1'b0;
            dir_ew_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= {bus.mn, bus.me, bus.ms, bus.mw};
            cur_q    <= cur_d;
            dir_ns_q <= dir_ns_d;
            dir_ew_q <= dir_ew_d;
        end

    assign bus.step_ns = step && (cur_q[3] || cur_q[1]);
    assign bus.step_ew = step && (cur_q[2] || cur_q[0]);
    assign bus.dir_ns  = dir_ns_q;
    assign bus.dir_ew  = dir_ew_q;
    assign bus.limit   = valid && blocked;
    assign bus.fault   = !$onehot0(req_q);
    assign bus.busy    = state_q != IDLE;
endmodule

// File: tb/tb_solar_motor_drive.sv
// tb_solar_motor_drive: segment table, corner sequences and random requests vs a timestamp-based model.
module tb_solar_motor_drive;
    localparam int SD = 4, DC = 3, PW = 8, PMAX = 255, PINIT = 128;
`ifdef SOLAR_DRV_SOFTLIMIT_EN
    localparam bit SL = 1'b1;
`else
    localparam bit SL = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, failures = 0;

    solar_motor_drive_if #(.POS_W(PW)) bus ();
    solar_motor_drive #(.STEP_DIV(SD), .DEAD_CYCLES(DC), .POS_W(PW), .POS_MAX(PMAX), .POS_INIT(PINIT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Model: the run phase is derived from the edge at which RUN began, dead-time from an end edge.
    int c, mode, e_run, dead_end, pos_n, pos_e;
    logic [3:0] m_req, m_cur;
    bit dn, de;

    function automatic void chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (edge %0d)", n, a, e, c);
        end
    endfunction

    function automatic void model_reset();
        c = 0; mode = 0; e_run = 0; dead_end = 0;
        pos_n = PINIT; pos_e = PINIT; m_req = 0; m_cur = 0; dn = 0; de = 0;
    endfunction

    function automatic bit m_blk(logic [3:0] r);
        return SL && ((r[3] && pos_n == PMAX) || (r[1] && pos_n == 0) ||
                      (r[2] && pos_e == PMAX) || (r[0] && pos_e == 0));
    endfunction

    function automatic bit m_phase();
        return mode == 1 && (c - e_run) % SD == SD - 1;
    endfunction

    function automatic bit m_step();
        return m_phase() && m_req == m_cur && !m_blk(m_req);
    endfunction

    function automatic void model_edge(logic [3:0] r);
        bit st = m_step(), ph = m_phase(), bk = m_blk(m_req);
        c++;
        if (st) begin
            if (m_cur[3]) pos_n++;
            if (m_cur[1]) pos_n--;
            if (m_cur[2]) pos_e++;
            if (m_cur[0]) pos_e--;
        end
        if (mode == 0 && $countones(m_req) == 1 && !bk) begin
            mode = 1; e_run = c; m_cur = m_req;
            if (m_req[3] || m_req[1]) dn = m_req[3]; else de = m_req[2];
        end else if (mode == 1 && (m_req != m_cur || (ph && bk))) begin
            mode = 2; dead_end = c + DC;
        end else if (mode == 2 && c == dead_end) begin
            mode = 0;
        end
        m_req = r;
    endfunction

    function automatic void compare_all();
        bit st = m_step();
        chk("step_ns", bus.step_ns, st && (m_cur[3] || m_cur[1]));
        chk("step_ew", bus.step_ew, st && (m_cur[2] || m_cur[0]));
        chk("dir_ns", bus.dir_ns, dn);
        chk("dir_ew", bus.dir_ew, de);
        chk("pos_ns", bus.pos_ns, SL ? pos_n : 0);
        chk("pos_ew", bus.pos_ew, SL ? pos_e : 0);
        chk("limit", bus.limit, $countones(m_req) == 1 && m_blk(m_req));
        chk("fault", bus.fault, $countones(m_req) > 1);
        chk("busy", bus.busy, mode != 0);
    endfunction

    task automatic cyc(input logic [3:0] r);
        {bus.mn, bus.me, bus.ms, bus.mw} = r;
        @(posedge clk);
        model_edge(r);
        #1 compare_all();
    endtask

    typedef struct {
        logic [3:0] req;
        int n, ns_steps, ew_steps;
        bit fault, busy;
    } seg_t;

    initial begin
        seg_t segs[6];
        int sn, se, k;
        logic [3:0] r;
        segs = '{'{4'b1000, 21, 5, 0, 0, 1},
                 '{4'b0000,  6, 0, 0, 0, 0},
                 '{4'b0100,  5, 0, 1, 0, 1},
                 '{4'b0001, 12, 0, 1, 0, 1},
                 '{4'b1100,  6, 0, 0, 1, 0},
                 '{4'b0000,  3, 0, 0, 0, 0}};
        {bus.mn, bus.me, bus.ms, bus.mw} = 4'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare_all();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sn = 0; se = 0;
            for (int j = 0; j < segs[i].n; j++) begin
                cyc(segs[i].req);
                sn += int'(bus.step_ns);
                se += int'(bus.step_ew);
            end
            chk($sformatf("seg%0d_ns_steps", i), sn, segs[i].ns_steps);
            chk($sformatf("seg%0d_ew_steps", i), se, segs[i].ew_steps);
            chk($sformatf("seg%0d_fault", i), bus.fault, segs[i].fault);
            chk($sformatf("seg%0d_busy", i), bus.busy, segs[i].busy);
        end

        // Drive south into the lower limit, then step back north.
        repeat (560) cyc(4'b0010);
        chk("low_limit", bus.limit, SL);
        chk("low_busy", bus.busy, !SL);
        chk("low_pos", bus.pos_ns, 0);
        repeat (12) cyc(4'b1000);
        chk("north_limit", bus.limit, 0);
        chk("north_busy", bus.busy, 1);
        repeat (8) cyc(4'b0000);

        // Asynchronous reset in the middle of a step pulse.
        k = 0;
        do begin cyc(4'b0100); k++; end while (!bus.step_ew && k < 20);
        chk("rst_step_seen", bus.step_ew, 1);
        {bus.mn, bus.me, bus.ms, bus.mw} = 4'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_step_ew", bus.step_ew, 0);
        chk("rst_dir_ew", bus.dir_ew, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pos_ew", bus.pos_ew, SL ? PINIT : 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        compare_all();

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            r = 4'b0;
            if (k >= 2 && k <= 7) r[$urandom_range(0, 3)] = 1'b1;
            if (k >= 8) begin
                r[$urandom_range(0, 1)] = 1'b1;
                r[$urandom_range(2, 3)] = 1'b1;
            end
            repeat ($urandom_range(1, 25)) cyc(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
